weight_ram_stream: RTL



---
 rtl/weight_ram_stream.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/weight_ram_stream.sv
// Purpose    : addressable weight RAM with a burst read engine that streams one neuron's fan-in to a MAC stage.
// Latency    : rd_start sampled at edge T, first beat valid after edge T+2, then one beat per clock.
// Backpressure: a 2-entry skid buffer absorbs the 1-cycle RAM latency; reads are only issued when a slot is guaranteed.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wr_enable, wr_addr, wr_data    write port, usable at any time (read-first on collision)
//   rd_start, rd_base, rd_len      single-cycle burst request; length clamped to the RAM depth
//   rd_ready                       downstream accepts o_data this cycle
//   o_data, o_valid, o_last        streamed weight, valid, final-beat marker
//   busy                           burst accepted and not fully delivered
//   err                            one-cycle pulse after an rd_start that arrived while busy
module weight_ram_stream #(
   parameter int    RAM_WIDTH     = 32,
   parameter int    RAM_ADDR_BITS = 5,
   parameter string DATA_FILE     = ""
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_enable,
   input  logic [RAM_ADDR_BITS-1:0] wr_addr,
   input  logic [RAM_WIDTH-1:0]     wr_data,
   input  logic                     rd_start,
   input  logic [RAM_ADDR_BITS-1:0] rd_base,
   input  logic [RAM_ADDR_BITS:0]   rd_len,
   input  logic                     rd_ready,
   output logic [RAM_WIDTH-1:0]     o_data,
   output logic                     o_valid,
   output logic                     o_last,
   output logic                     busy,
   output logic                     err
);

   localparam int DEPTH = 2**RAM_ADDR_BITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [RAM_ADDR_BITS:0]   MAX_LEN  = (RAM_ADDR_BITS+1)'(DEPTH);
   localparam logic [RAM_ADDR_BITS:0]   LEN_ONE  = (RAM_ADDR_BITS+1)'(1);
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);

   // storage
   logic [RAM_WIDTH-1:0] mem [DEPTH];
   logic [RAM_WIDTH-1:0] ram_q;

   // read engine
   logic [1:0]               state;
   logic [RAM_ADDR_BITS-1:0] rd_addr;
   logic [RAM_ADDR_BITS:0]   issue_left;   // reads still to be issued in this burst
   logic [RAM_ADDR_BITS:0]   start_len;
   logic                     rd_en;
   logic                     ram_vld;      // ram_q holds a word that enters the buffer next edge
   logic                     ram_last;     // that word is the final beat of the burst

   // skid buffer, entry 0 is the head presented on the output
   logic [RAM_WIDTH-1:0] buf0_dat;
   logic [RAM_WIDTH-1:0] buf1_dat;
   logic                 buf0_last;
   logic                 buf1_last;
   logic [1:0]           occ;
   logic                 push;
   logic                 pop;

   assign start_len = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;

   assign push = ram_vld;
   assign pop  = (occ != 2'd0) && rd_ready;

   // A read is issued only if its word is guaranteed a buffer slot: buffered plus in-flight
   // words must stay below two, counting the beat that leaves this cycle so that a
   // continuously ready consumer sees no bubbles.
   assign rd_en = (state == S_READ) && ((({1'b0, ram_vld} + occ) < 2'd2) || pop);

   assign o_data  = buf0_dat;
   assign o_valid = (occ != 2'd0);
   assign o_last  = buf0_last && (occ != 2'd0);
   assign busy    = (state != S_IDLE);

   // Block-RAM style array: no reset, read-first on a same-address write.
   always_ff @(posedge clk) begin
      if (wr_enable) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         ram_q <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_addr    <= '0;
         issue_left <= '0;
         ram_vld    <= 1'b0;
         ram_last   <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Any request seen while not idle is dropped, including the cycle the last beat leaves.
         err     <= rd_start && (state != S_IDLE);
         ram_vld <= rd_en;
         if (rd_en) begin
            ram_last <= (issue_left == LEN_ONE);
         end
         case (state)
            S_IDLE: begin
               if (rd_start && (rd_len != '0)) begin
                  rd_addr    <= rd_base;
                  issue_left <= start_len;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               if (rd_en) begin
                  // address wraps naturally at the RAM depth
                  rd_addr    <= rd_addr + ADDR_ONE;
                  issue_left <= issue_left - LEN_ONE;
                  if (issue_left == LEN_ONE) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && buf0_last) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= 2'd0;
         buf0_dat  <= '0;
         buf0_last <= 1'b0;
         buf1_dat  <= '0;
         buf1_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  buf0_dat  <= ram_q;
                  buf0_last <= ram_last;
               end else begin
                  buf1_dat  <= ram_q;
                  buf1_last <= ram_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf0_dat  <= buf1_dat;
               buf0_last <= buf1_last;
               occ       <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  buf0_dat  <= ram_q;
                  buf0_last <= ram_last;
               end else begin
                  buf0_dat  <= buf1_dat;
                  buf0_last <= buf1_last;
                  buf1_dat  <= ram_q;
                  buf1_last <= ram_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
